// File: rtl/wash_panel_ctrl.sv
// wash_panel_ctrl
// Front-panel input conditioner and launch sequencer for the washing-machine
// cycle controller. It synchronises and debounces the buttons, program
// switches and door sensor. It issues a one-cycle start with a frozen program
// selection, and it tracks launch, run and finish from machine_done.
//
// Parameters:
//   DB_CNT    - consecutive differing cycles before a debounced input flips (2..15)
//   LAUNCH_TO - cycles allowed in LAUNCH for machine_done to fall (1..255)
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   btn_start_raw    - raw start button
//   btn_pause_raw    - raw pause button
//   sw_double_raw    - raw double-wash switch
//   sw_dry_raw       - raw dry-wash switch
//   door_sensor_raw  - raw door sensor (1 = closed)
//   machine_done     - controller idle flag
//   start            - one-cycle start pulse
//   double_wash      - latched double-wash selection
//   dry_wash         - latched dry-wash selection
//   time_pause       - pause level (only ever 1 while running)
//   door_closed      - debounced door status
//   busy             - 1 whenever the sequencer is not READY
//   launch_err       - sticky launch-failure flag
//   cycle_count      - completed-cycle counter
//
// Optional feature: define CYCLE_COUNT_EN to get an 8-bit saturating count of
// completed cycles. Without it, cycle_count is tied to zero.

module wash_panel_ctrl #(
  parameter int DB_CNT    = 4,
  parameter int LAUNCH_TO = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       sw_double_raw,
  input  logic       sw_dry_raw,
  input  logic       door_sensor_raw,
  input  logic       machine_done,
  output logic       start,
  output logic       double_wash,
  output logic       dry_wash,
  output logic       time_pause,
  output logic       door_closed,
  output logic       busy,
  output logic       launch_err,
  output logic [7:0] cycle_count
);

  localparam int         NIN     = 5;
  localparam logic [3:0] DB_LAST = 4'(DB_CNT - 1);
  localparam logic [7:0] TO_LAST = 8'(LAUNCH_TO - 1);

  typedef enum logic [1:0] {READY, LAUNCH, RUNNING} state_t;

  // Bit order: 0 start, 1 pause, 2 double, 3 dry, 4 door
  logic [NIN-1:0] raw_vec;
  logic [NIN-1:0] sync_q1;
  logic [NIN-1:0] sync_q2;
  logic [NIN-1:0] deb;
  logic [1:0]     btn_d;
  logic [3:0]     db_cnt [NIN];

  logic   start_edge;
  logic   pause_edge;
  state_t state, state_n;
  logic [7:0] timer, timer_n;
  logic   start_n, dbl_n, dry_n, pause_n, err_n;

  assign raw_vec = {door_sensor_raw, sw_dry_raw, sw_double_raw, btn_pause_raw, btn_start_raw};

  // Two-flop synchroniser. btn_d holds last cycle's debounced buttons, which
  // the rising-edge detectors need.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      btn_d   <= '0;
    end else begin
      sync_q1 <= raw_vec;
      sync_q2 <= sync_q1;
      btn_d   <= deb[1:0];
    end
  end

  // Each input flips only after DB_CNT consecutive cycles of disagreement.
  // Any agreement restarts the count, so shorter glitches never get through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync_q2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign start_edge  = deb[0] & ~btn_d[0];
  assign pause_edge  = deb[1] & ~btn_d[1];
  assign door_closed = deb[4];

  // machine_done comes from the cycle controller on the same clock, so it is
  // used without synchronisation.
  always_comb begin
    state_n = state;
    timer_n = timer;
    start_n = 1'b0;
    dbl_n   = double_wash;
    dry_n   = dry_wash;
    pause_n = time_pause;
    err_n   = launch_err;
    case (state)
      READY: begin
        dbl_n   = deb[2];
        dry_n   = deb[3];
        pause_n = 1'b0;
        if (start_edge && door_closed && machine_done) begin
          start_n = 1'b1;
          state_n = LAUNCH;
          timer_n = '0;
        end
      end
      LAUNCH: begin
        if (!machine_done) begin
          state_n = RUNNING;
          err_n   = 1'b0;
        end else if (timer == TO_LAST) begin
          err_n   = 1'b1;
          state_n = READY;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      RUNNING: begin
        if (machine_done) begin
          state_n = READY;
          pause_n = 1'b0;
        end else if (pause_edge) begin
          pause_n = ~time_pause;
        end
      end
      default: state_n = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= READY;
      timer       <= '0;
      start       <= 1'b0;
      double_wash <= 1'b0;
      dry_wash    <= 1'b0;
      time_pause  <= 1'b0;
      launch_err  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      start       <= start_n;
      double_wash <= dbl_n;
      dry_wash    <= dry_n;
      time_pause  <= pause_n;
      launch_err  <= err_n;
      busy        <= (state_n != READY);
    end
  end

`ifdef CYCLE_COUNT_EN
  // A cycle is complete on the RUNNING->READY transition. The count holds at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state == RUNNING && machine_done && cycle_count != 8'hFF) begin
      cycle_count <= cycle_count + 8'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

endmodule
